// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single memory port.
// Latches the winning request, waits for mem_ready or a watchdog timeout, then acks for one cycle.
module mem_port_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              owner,
  output logic              busy,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err_q, err_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt;
  logic              expired;

  // On a tie the port that was not served last wins.
  assign gnt     = (req0 && req1) ? ~last_q : req1;
  assign expired = (cnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    err_d       = err_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d     = gnt;
          mem_addr_d  = gnt ? addr1 : addr0;
          mem_wdata_d = gnt ? wdata1 : wdata0;
          mem_we_d    = gnt ? we1 : we0;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        // mem_ready takes priority over an expiring watchdog.
        if (mem_ready || expired) begin
          rdata_d   = mem_ready ? mem_rdata : '0;
          err_d     = ~mem_ready;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = owner_q;
          ack0_d    = ~owner_q;
          ack1_d    = owner_q;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign busy      = (state_q != StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vectors plus hand sequences for
// round-robin, watchdog timeout, timeout boundary and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err, owner, busy, mem_req, mem_we, mem_ready;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1),
    .rdata(rdata), .err(err), .owner(owner), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acks must never overlap.
  always @(negedge clk) begin
    if (rst === 1'b0) check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        mrdy;
    logic [31:0] mrdata;
    logic        e_ack0;
    logic        e_ack1;
    logic        e_err;
    logic        e_owner;
    logic        e_busy;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];
  int   n;
  bit   seen;

  initial begin
    // Inputs applied before the edge, outputs expected after it.
    vecs[0]  = '{1, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h0};
    vecs[1]  = '{0, 1, 32'h40,  0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,1,1,0, 32'h40,  32'h0, 32'h0};
    vecs[2]  = '{0, 1, 32'h44,  0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,1,1,0, 32'h40,  32'h0, 32'h0};
    vecs[3]  = '{0, 1, 32'h44,  0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,1,1,0, 32'h40,  32'h0, 32'h0};
    vecs[4]  = '{0, 1, 32'h44,  0, 0, 32'h0,   32'h0, 1, 32'hDEADBEEF, 1,0,0,0,1,0,0, 32'h40,  32'h0, 32'hDEADBEEF};
    vecs[5]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,0,0,0, 32'h40,  32'h0, 32'hDEADBEEF};
    vecs[6]  = '{1, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h0};
    vecs[7]  = '{0, 1, 32'h100, 1, 1, 32'h200, 32'hE, 1, 32'h11,       0,0,0,0,1,1,0, 32'h100, 32'h0, 32'h0};
    vecs[8]  = '{0, 1, 32'h100, 1, 1, 32'h200, 32'hE, 1, 32'h11,       1,0,0,0,1,0,0, 32'h100, 32'h0, 32'h11};
    vecs[9]  = '{0, 0, 32'h0,   1, 1, 32'h200, 32'hE, 1, 32'h11,       0,0,0,0,0,0,0, 32'h100, 32'h0, 32'h11};
    vecs[10] = '{0, 0, 32'h0,   1, 1, 32'h200, 32'hE, 0, 32'h0,        0,0,0,1,1,1,1, 32'h200, 32'hE, 32'h11};
    vecs[11] = '{0, 0, 32'h0,   1, 1, 32'h200, 32'hE, 1, 32'h22,       0,1,0,1,1,0,0, 32'h200, 32'hE, 32'h22};
    vecs[12] = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 32'h0,        0,0,0,1,0,0,0, 32'h200, 32'hE, 32'h22};

    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_ready = 0; mem_rdata = 0;
    tick();

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; req0 = vecs[i].req0; addr0 = vecs[i].addr0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
      mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrdata;
      tick();
      check($sformatf("v%0d ack0", i), {31'd0, ack0}, {31'd0, vecs[i].e_ack0});
      check($sformatf("v%0d ack1", i), {31'd0, ack1}, {31'd0, vecs[i].e_ack1});
      check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
      check($sformatf("v%0d owner", i), {31'd0, owner}, {31'd0, vecs[i].e_owner});
      check($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mreq});
      check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_mwe});
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      check($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
    end

    // Round-robin: both ports held high for six accesses.
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1; req1 = 1; we1 = 0; addr0 = 32'h10; addr1 = 32'h20; mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        seen = mem_req;
      end
      check($sformatf("rr%0d granted", i), {31'd0, seen}, 32'd1);
      check($sformatf("rr%0d owner", i), {31'd0, owner}, i % 2);
      check($sformatf("rr%0d mem_addr", i), mem_addr, (i % 2) ? 32'h20 : 32'h10);
      mem_ready = 1; mem_rdata = 32'hA0 + i;
      tick();
      check($sformatf("rr%0d ack0", i), {31'd0, ack0}, (i % 2) ? 32'd0 : 32'd1);
      check($sformatf("rr%0d ack1", i), {31'd0, ack1}, (i % 2) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d rdata", i), rdata, 32'hA0 + i);
      mem_ready = 0;
      tick();
    end
    req0 = 0; req1 = 0;
    tick();

    // Watchdog: mem_ready never arrives.
    req0 = 1; addr0 = 32'h300;
    tick();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("to mem_req_cycles", n, 32'd15);
    check("to ack0", {31'd0, ack0}, 32'd1);
    check("to err", {31'd0, err}, 32'd1);
    check("to rdata", rdata, 32'd0);
    req0 = 0;
    tick();
    check("to idle busy", {31'd0, busy}, 32'd0);
    check("to idle err", {31'd0, err}, 32'd0);
    check("to idle ack0", {31'd0, ack0}, 32'd0);

    // mem_ready on the 15th BUSY cycle beats the watchdog.
    req0 = 1; addr0 = 32'h304;
    tick();
    repeat (14) tick();
    check("bnd still busy", {31'd0, mem_req}, 32'd1);
    check("bnd no early ack", {31'd0, ack0}, 32'd0);
    mem_ready = 1; mem_rdata = 32'hF0;
    tick();
    check("bnd ack0", {31'd0, ack0}, 32'd1);
    check("bnd err", {31'd0, err}, 32'd0);
    check("bnd rdata", rdata, 32'hF0);
    mem_ready = 0; req0 = 0;
    tick();

    // Reset during a port 1 write, then a normal port 0 read.
    req1 = 1; we1 = 1; addr1 = 32'h400; wdata1 = 32'h55;
    tick();
    check("rst pre owner", {31'd0, owner}, 32'd1);
    check("rst pre mem_we", {31'd0, mem_we}, 32'd1);
    tick();
    rst = 1; mem_ready = 1; mem_rdata = 32'h99;
    tick();
    check("rst ack0", {31'd0, ack0}, 32'd0);
    check("rst ack1", {31'd0, ack1}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst owner", {31'd0, owner}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst rdata", rdata, 32'd0);
    rst = 0; mem_ready = 0; req1 = 0; we1 = 0; req0 = 1; addr0 = 32'h500;
    tick();
    check("post mem_req", {31'd0, mem_req}, 32'd1);
    check("post mem_addr", mem_addr, 32'h500);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    check("post ack0", {31'd0, ack0}, 32'd1);
    check("post ack1", {31'd0, ack1}, 32'd0);
    check("post rdata", rdata, 32'h77);
    mem_ready = 0; req0 = 0;
    tick();
    check("post idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for a single 32-bit memory port.
- Lets instruction fetch (port 0) and data access (port 1) share one memory.
- Latches the winning request, drives the shared address/data path, waits for the memory handshake, and returns the read data with a one-cycle ack.
- Round-robin on conflicts; a watchdog aborts stalled accesses.

Parameters:
- DATA_W, 32, width of address, write data and read data.
- TIMEOUT, 15, max BUSY cycles without mem_ready before abort (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req0  input  1  port 0 request, held high until ack0.
- addr0  input  DATA_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- we0  input  1  port 0 write enable.
- ack0  output  1  one-cycle completion pulse for port 0.
- req1  input  1  port 1 request, held high until ack1.
- addr1  input  DATA_W  port 1 address.
- wdata1  input  DATA_W  port 1 write data.
- we1  input  1  port 1 write enable.
- ack1  output  1  one-cycle completion pulse for port 1.
- rdata  output  DATA_W  read data, valid while ack0/ack1 is high.
- err  output  1  high with ack when the access timed out.
- owner  output  1  currently/last granted port (0/1).
- busy  output  1  high in BUSY and RESP.
- mem_req  output  1  memory request.
- mem_addr  output  DATA_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DATA_W  memory read data.
- mem_ready  input  1  memory completion, sampled only in BUSY.

Behaviour:
- Reset values: state IDLE; ack0, ack1, err, busy, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata = 0; owner = 0; last_served = 1, so port 0 wins the first tie; wait counter = 0.
- Reset mid-operation: the access is dropped, no ack is issued, and all outputs return to reset values on the next edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one req: grant it.
- IDLE, both req: grant the port != last_served.
- IDLE, on grant: on that edge latch addr, wdata and we into mem_addr, mem_wdata and mem_we; set owner; set mem_req = 1; clear the counter; go to BUSY. mem_req therefore rises 1 cycle after req is first seen.
- BUSY, mem_req and latched mem outputs: held stable; requester inputs are ignored.
- BUSY, counter: increments each cycle mem_ready = 0.
- BUSY, mem_ready = 1: on that edge rdata <= mem_rdata (also on writes), err <= 0, mem_req <= 0, mem_we <= 0, last_served <= owner, ack[owner] <= 1; go to RESP.
- BUSY, timeout: if mem_ready = 0 and counter == TIMEOUT-1, same actions but rdata <= 0 and err <= 1.
- BUSY, mem_ready on the expiry cycle: mem_ready wins and err = 0.
- RESP: exactly one cycle. ack and err are visible here. The requester must deassert req or present a new request by the end of this cycle. Next edge: ack0, ack1 and err <= 0; go to IDLE. req is not evaluated in RESP.
- Back-to-back: a request still high in the next IDLE cycle is treated as new. Minimum turnaround is 3 cycles per access (IDLE → BUSY → RESP) with a zero-wait memory.
- busy: = (state != IDLE).
- mem_ready outside BUSY: ignored.
- Exclusivity: ack0 and ack1 are never high together.
- Request validity: changes to addrN/wdataN/weN after grant have no effect on the access in flight.
- Starvation bound: a continuously asserted request is granted within one other access.

Test Plan:
- Single read, port 0, addr0 = 0x00000040, memory ready after 2 wait cycles with mem_rdata = 0xDEADBEEF → mem_req high 1 cycle after req0, mem_addr = 0x40, ack0 one cycle with rdata = 0xDEADBEEF, err = 0, ack1 never high.
- Simultaneous requests after reset, port 0 addr 0x100, port 1 write addr 0x200 wdata 0x0000000E, zero-wait memory → port 0 served first; port 1 next with mem_we = 1, mem_wdata = 0x0E; owner toggles 0 → 1.
- Both ports held high for 6 accesses → grants alternate 0,1,0,1,0,1; no port is served twice in a row.
- Timeout, TIMEOUT = 15, mem_ready never asserted → mem_req high exactly 15 cycles, then ack with err = 1 and rdata = 0, then IDLE.
- Timeout boundary, mem_ready on the 15th BUSY cycle with mem_rdata = 0xF0 → err = 0, rdata = 0xF0.
- rst pulsed in BUSY → next cycle all outputs zero, no ack; a new req0 is then served normally.
